// File: rtl/lcd_pkg.sv
// Shared definitions for the HD44780 status writer: controller command bytes,
// ASCII codes for the fixed text, FSM state encodings, frame geometry and a
// nibble-to-ASCII helper used when rendering hex digits.
package lcd_pkg;

  // Controller commands
  localparam logic [7:0] FUNC_SET = 8'h38;  // 8-bit bus, 2 lines, 5x8 font
  localparam logic [7:0] DISP_ON  = 8'h0C;  // display on, cursor off
  localparam logic [7:0] CLEAR    = 8'h01;  // clear display (slow command)
  localparam logic [7:0] ENTRY    = 8'h06;  // increment address, no shift
  localparam logic [7:0] LINE1    = 8'h80;  // DDRAM address 0x00
  localparam logic [7:0] LINE2    = 8'hC0;  // DDRAM address 0x40

  // ASCII for the fixed text
  localparam logic [7:0] CH_SP = 8'h20;
  localparam logic [7:0] CH_1  = 8'h31;
  localparam logic [7:0] CH_C  = 8'h43;
  localparam logic [7:0] CH_E  = 8'h45;
  localparam logic [7:0] CH_F  = 8'h46;
  localparam logic [7:0] CH_I  = 8'h49;
  localparam logic [7:0] CH_M  = 8'h4D;
  localparam logic [7:0] CH_P  = 8'h50;
  localparam logic [7:0] CH_X  = 8'h58;

  // Frame layout: byte indices of the two address commands, the last byte,
  // and the first hex digit of each value.
  localparam logic [5:0] IDX_LINE2   = 6'd17;
  localparam logic [5:0] IDX_LAST    = 6'd33;
  localparam logic [5:0] IDX_PC0     = 6'd4;
  localparam logic [5:0] IDX_REG0    = 6'd21;
  localparam logic [5:0] INIT_BYTES  = 6'd5;

  typedef enum logic [1:0] {ST_PWRUP, ST_INIT, ST_FRAME} lcd_state_e;

  typedef enum logic [1:0] {TX_IDLE, TX_SETUP, TX_EN, TX_WAIT} tx_state_e;

  // 0-9 -> '0'-'9', A-F -> 'A'-'F'
  function automatic logic [7:0] nib2ascii(input logic [3:0] n);
    return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
  endfunction

endpackage

// File: rtl/lcd_byte_tx.sv
// One HD44780 byte write. A start pulse latches rs/data/long_wait; the next
// cycle (t0) presents RS/DATA with EN low, then EN is high for EN_CYCLES
// clocks, then low for CMD_WAIT (or CLR_WAIT when long_wait) clocks.
// done_o is asserted combinationally in the last wait cycle so the parent can
// issue the next start in that same cycle and the following t0 has no gap.
// Ports:
//   clk, rst          clock, async active-high reset
//   start_i           begin a transfer (accepted when idle or on done_o)
//   rs_i, data_i      byte to send and its register select
//   long_wait_i       use CLR_WAIT for the trailing idle time
//   done_o            last idle cycle of the current transfer
//   lcd_en_o/rs_o/data_o  registered LCD pins
module lcd_byte_tx
  import lcd_pkg::*;
#(
  parameter int EN_CYCLES = 12,
  parameter int CMD_WAIT  = 2000,
  parameter int CLR_WAIT  = 82000,
  parameter int CNT_W     = 17
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start_i,
  input  logic       rs_i,
  input  logic [7:0] data_i,
  input  logic       long_wait_i,
  output logic       done_o,
  output logic       lcd_en_o,
  output logic       lcd_rs_o,
  output logic [7:0] lcd_data_o
);

  tx_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             en_q, en_d;
  logic             rs_q, rs_d;
  logic [7:0]       data_q, data_d;
  logic             long_q, long_d;
  logic [CNT_W-1:0] wait_last;

  assign wait_last = long_q ? CNT_W'(CLR_WAIT - 1) : CNT_W'(CMD_WAIT - 1);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    en_d    = 1'b0;
    rs_d    = rs_q;
    data_d  = data_q;
    long_d  = long_q;
    done_o  = 1'b0;
    unique case (state_q)
      TX_IDLE: begin
        if (start_i) begin
          rs_d    = rs_i;
          data_d  = data_i;
          long_d  = long_wait_i;
          state_d = TX_SETUP;
        end
      end
      TX_SETUP: begin
        en_d    = 1'b1;
        cnt_d   = '0;
        state_d = TX_EN;
      end
      TX_EN: begin
        if (cnt_q == CNT_W'(EN_CYCLES - 1)) begin
          cnt_d   = '0;
          state_d = TX_WAIT;
        end else begin
          en_d  = 1'b1;
          cnt_d = cnt_q + 1'b1;
        end
      end
      TX_WAIT: begin
        if (cnt_q == wait_last) begin
          done_o = 1'b1;
          if (start_i) begin
            rs_d    = rs_i;
            data_d  = data_i;
            long_d  = long_wait_i;
            state_d = TX_SETUP;
          end else begin
            state_d = TX_IDLE;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = TX_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= TX_IDLE;
      cnt_q   <= '0;
      en_q    <= 1'b0;
      rs_q    <= 1'b0;
      data_q  <= 8'h00;
      long_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      en_q    <= en_d;
      rs_q    <= rs_d;
      data_q  <= data_d;
      long_q  <= long_d;
    end
  end

  assign lcd_en_o   = en_q;
  assign lcd_rs_o   = rs_q;
  assign lcd_data_o = data_q;

endmodule

// File: rtl/lcd_status_writer.sv
// HD44780 16x2 status display for the RISC-V core. After reset it waits
// PWRUP_WAIT clocks, sends the init commands, then loops forever sending a
// 34-byte frame: "PC xxxxxxxx     " on line 1 and "X1 xxxxxxxx EXEC|FIM "
// on line 2, from a snapshot taken as each frame's first byte starts.
// Ports:
//   clk, rst        50 MHz clock, async active-high reset
//   pc, register    values rendered as 8 uppercase hex digits
//   final_flag      execution finished (the core's `final`; renamed because
//                   `final` is a SystemVerilog keyword)
//   LCD_data/en/rw/rs/blon  registered LCD pins (rw is always 0)
//   frame_done      one-cycle pulse as each new frame begins after the last
module lcd_status_writer
  import lcd_pkg::*;
#(
  parameter int EN_CYCLES  = 12,
  parameter int CMD_WAIT   = 2000,
  parameter int CLR_WAIT   = 82000,
  parameter int PWRUP_WAIT = 750000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc,
  input  logic [31:0] register,
  input  logic        final_flag,
  output logic [7:0]  LCD_data,
  output logic        LCD_en,
  output logic        LCD_rw,
  output logic        LCD_rs,
  output logic        LCD_blon,
  output logic        frame_done
);

  localparam int MAXW  = (PWRUP_WAIT > CLR_WAIT) ? PWRUP_WAIT : CLR_WAIT;
  localparam int CNT_W = $clog2(MAXW + 1);

  lcd_state_e       state_q, state_d;
  logic [5:0]       idx_q, idx_d;       // next byte to send within INIT/FRAME
  logic [CNT_W-1:0] pw_cnt_q, pw_cnt_d;
  logic [31:0]      pc_q, reg_q;
  logic             fin_q;
  logic             snap_ld;
  logic             fdone_q, fdone_d;
  logic             blon_q, rw_q;

  logic             tx_start, tx_rs, tx_done, tx_long;
  logic [7:0]       tx_data;
  logic [7:0]       init_byte;
  logic [7:0]       fb_data;
  logic             fb_rs;
  logic [5:0]       k;
  logic [4:0]       sh;

  // Init command for the current index (index 0 is issued from PWRUP)
  always_comb begin
    unique case (idx_q[2:0])
      3'd2:    init_byte = DISP_ON;
      3'd3:    init_byte = CLEAR;
      3'd4:    init_byte = ENTRY;
      default: init_byte = FUNC_SET;
    endcase
  end

  // Frame byte for the current index, rendered from the snapshot
  always_comb begin
    fb_rs   = 1'b1;
    fb_data = CH_SP;
    k       = 6'd0;
    sh      = 5'd0;
    unique case (idx_q)
      6'd0:      begin fb_rs = 1'b0; fb_data = LINE1; end
      6'd1:      fb_data = CH_P;
      6'd2:      fb_data = CH_C;
      IDX_LINE2: begin fb_rs = 1'b0; fb_data = LINE2; end
      6'd18:     fb_data = CH_X;
      6'd19:     fb_data = CH_1;
      6'd30:     fb_data = fin_q ? CH_F  : CH_E;
      6'd31:     fb_data = fin_q ? CH_I  : CH_X;
      6'd32:     fb_data = fin_q ? CH_M  : CH_E;
      6'd33:     fb_data = fin_q ? CH_SP : CH_C;
      default: begin
        if (idx_q >= IDX_PC0 && idx_q < IDX_PC0 + 6'd8) begin
          k       = idx_q - IDX_PC0;
          sh      = {3'd7 - k[2:0], 2'b00};   // most-significant nibble first
          fb_data = nib2ascii(pc_q[sh +: 4]);
        end else if (idx_q >= IDX_REG0 && idx_q < IDX_REG0 + 6'd8) begin
          k       = idx_q - IDX_REG0;
          sh      = {3'd7 - k[2:0], 2'b00};
          fb_data = nib2ascii(reg_q[sh +: 4]);
        end
      end
    endcase
  end

  // Sequencer: on each tx done the next byte is started in the same cycle
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    pw_cnt_d = pw_cnt_q;
    tx_start = 1'b0;
    tx_rs    = 1'b0;
    tx_data  = 8'h00;
    snap_ld  = 1'b0;
    fdone_d  = 1'b0;
    unique case (state_q)
      ST_PWRUP: begin
        if (pw_cnt_q == CNT_W'(PWRUP_WAIT - 1)) begin
          tx_start = 1'b1;
          tx_data  = FUNC_SET;
          idx_d    = 6'd1;
          state_d  = ST_INIT;
        end else begin
          pw_cnt_d = pw_cnt_q + 1'b1;
        end
      end
      ST_INIT: begin
        if (tx_done) begin
          tx_start = 1'b1;
          if (idx_q == INIT_BYTES) begin
            tx_data = LINE1;
            snap_ld = 1'b1;
            idx_d   = 6'd1;
            state_d = ST_FRAME;
          end else begin
            tx_data = init_byte;
            idx_d   = idx_q + 6'd1;
          end
        end
      end
      ST_FRAME: begin
        if (tx_done) begin
          tx_start = 1'b1;
          if (idx_q == IDX_LAST + 6'd1) begin
            // wrap: next frame's LINE1 starts now, snapshot taken with it
            tx_data = LINE1;
            snap_ld = 1'b1;
            fdone_d = 1'b1;
            idx_d   = 6'd1;
          end else begin
            tx_rs   = fb_rs;
            tx_data = fb_data;
            idx_d   = idx_q + 6'd1;
          end
        end
      end
      default: state_d = ST_PWRUP;
    endcase
  end

  assign tx_long = !tx_rs && (tx_data == CLEAR);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_PWRUP;
      idx_q    <= 6'd0;
      pw_cnt_q <= '0;
      pc_q     <= 32'h0;
      reg_q    <= 32'h0;
      fin_q    <= 1'b0;
      fdone_q  <= 1'b0;
      blon_q   <= 1'b0;
      rw_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      pw_cnt_q <= pw_cnt_d;
      fdone_q  <= fdone_d;
      blon_q   <= 1'b1;
      rw_q     <= 1'b0;
      if (snap_ld) begin
        pc_q  <= pc;
        reg_q <= register;
        fin_q <= final_flag;
      end
    end
  end

  lcd_byte_tx #(
    .EN_CYCLES (EN_CYCLES),
    .CMD_WAIT  (CMD_WAIT),
    .CLR_WAIT  (CLR_WAIT),
    .CNT_W     (CNT_W)
  ) u_tx (
    .clk         (clk),
    .rst         (rst),
    .start_i     (tx_start),
    .rs_i        (tx_rs),
    .data_i      (tx_data),
    .long_wait_i (tx_long),
    .done_o      (tx_done),
    .lcd_en_o    (LCD_en),
    .lcd_rs_o    (LCD_rs),
    .lcd_data_o  (LCD_data)
  );

  assign LCD_rw     = rw_q;
  assign LCD_blon   = blon_q;
  assign frame_done = fdone_q;

endmodule

// File: tb/tb_lcd_status_writer.sv
// Directed bench for lcd_status_writer with short timing parameters.
// Expected LCD bytes are queued as stimulus is set up and popped on each
// LCD_en falling edge; a per-cycle monitor checks strobe shape, gaps, bus
// stability, rw and frame_done spacing.
module tb_lcd_status_writer;

  localparam int EN_C = 2, CMD_W = 4, CLR_W = 8, PWR_W = 10;
  localparam int BYTE_CLK  = 1 + EN_C + CMD_W;
  localparam int FRAME_CLK = 34 * BYTE_CLK;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] pc = 32'h0, register = 32'h0;
  logic        final_flag = 1'b0;
  logic [7:0]  LCD_data;
  logic        LCD_en, LCD_rw, LCD_rs, LCD_blon, frame_done;

  lcd_status_writer #(
    .EN_CYCLES(EN_C), .CMD_WAIT(CMD_W), .CLR_WAIT(CLR_W), .PWRUP_WAIT(PWR_W)
  ) dut (
    .clk(clk), .rst(rst), .pc(pc), .register(register), .final_flag(final_flag),
    .LCD_data(LCD_data), .LCD_en(LCD_en), .LCD_rw(LCD_rw), .LCD_rs(LCD_rs),
    .LCD_blon(LCD_blon), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  int         n_cmp = 0, n_err = 0;
  logic [8:0] sb_q[$];   // {rs, data}
  logic       sb_on = 1'b1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push_init();
    sb_q.push_back({1'b0, 8'h38});
    sb_q.push_back({1'b0, 8'h38});
    sb_q.push_back({1'b0, 8'h0C});
    sb_q.push_back({1'b0, 8'h01});
    sb_q.push_back({1'b0, 8'h06});
  endtask

  task automatic push_frame(input logic [31:0] p, input logic [31:0] r, input logic f);
    string hx, l1, l2;
    hx = "0123456789ABCDEF";
    l1 = "PC ";
    l2 = "X1 ";
    for (int i = 7; i >= 0; i--) begin
      l1 = {l1, hx.substr(int'((p >> (4 * i)) & 32'hF), int'((p >> (4 * i)) & 32'hF))};
      l2 = {l2, hx.substr(int'((r >> (4 * i)) & 32'hF), int'((r >> (4 * i)) & 32'hF))};
    end
    l1 = {l1, "     "};
    l2 = {l2, " ", (f ? "FIM " : "EXEC")};
    sb_q.push_back({1'b0, 8'h80});
    for (int i = 0; i < 16; i++) sb_q.push_back({1'b1, l1[i]});
    sb_q.push_back({1'b0, 8'hC0});
    for (int i = 0; i < 16; i++) sb_q.push_back({1'b1, l2[i]});
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 3000 && sb_q.size() != 0; i++) @(negedge clk);
    chk(tag, 32'(sb_q.size()), 32'd0);
  endtask

  // After release: blon on the first clock, first EN rise after PWR_W+1 clocks
  task automatic pwrup_check(input string tag);
    int cyc;
    cyc = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
      if (cyc == 1) chk({tag, "_blon"}, 32'(LCD_blon), 32'd1);
      if (LCD_en) break;
    end
    chk({tag, "_first_en"}, 32'(cyc), 32'(PWR_W + 1));
  endtask

  // Protocol monitor
  logic       en_p = 1'b0, rs_p = 1'b0, seen = 1'b0, last_clr = 1'b0, fd_seen = 1'b0;
  logic [7:0] data_p = 8'h00;
  int         hi_run = 0, lo_run = 0, fd_cnt = 0;
  logic [8:0] exp_b;

  always @(negedge clk) begin
    chk("rw_low", 32'(LCD_rw), 32'd0);
    if (rst) begin
      en_p = 1'b0; seen = 1'b0; fd_seen = 1'b0; hi_run = 0; lo_run = 0;
    end else begin
      fd_cnt++;
      if (frame_done) begin
        chk("fd_at_line1", {23'd0, LCD_rs, LCD_data}, {23'd0, 1'b0, 8'h80});
        if (fd_seen) chk("fd_period", 32'(fd_cnt), 32'(FRAME_CLK));
        fd_seen = 1'b1;
        fd_cnt  = 0;
      end
      if (LCD_en && !en_p) begin
        // low run includes the t0 setup cycle of this byte
        if (seen) chk("en_gap", 32'(lo_run), 32'((last_clr ? CLR_W : CMD_W) + 1));
        hi_run = 1;
      end else if (LCD_en && en_p) begin
        hi_run++;
        chk("bus_stable", {23'd0, LCD_rs, LCD_data}, {23'd0, rs_p, data_p});
      end else if (!LCD_en && en_p) begin
        chk("en_width", 32'(hi_run), 32'(EN_C));
        seen     = 1'b1;
        last_clr = !LCD_rs && (LCD_data == 8'h01);
        lo_run   = 1;
        if (sb_on) begin
          if (sb_q.size() == 0) begin
            chk("unexpected_byte", {23'd0, LCD_rs, LCD_data}, 32'hFFFF_FFFF);
          end else begin
            exp_b = sb_q.pop_front();
            chk("byte", {23'd0, LCD_rs, LCD_data}, {23'd0, exp_b});
          end
        end
      end else begin
        lo_run++;
      end
      en_p   = LCD_en;
      rs_p   = LCD_rs;
      data_p = LCD_data;
    end
  end

  initial begin
    pc = 32'h0000_001C; register = 32'h0000_00AF; final_flag = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_data", 32'(LCD_data), 32'h0);
    chk("rst_en",   32'(LCD_en), 32'd0);
    chk("rst_rs",   32'(LCD_rs), 32'd0);
    chk("rst_blon", 32'(LCD_blon), 32'd0);
    chk("rst_fd",   32'(frame_done), 32'd0);

    push_init();
    push_frame(32'h0000_001C, 32'h0000_00AF, 1'b0);
    rst = 1'b0;
    pwrup_check("pwrup1");

    // Mid-frame input change must not leak into the current frame
    for (int i = 0; i < 2000 && sb_q.size() > 20; i++) @(negedge clk);
    chk("mid_frame_reached", 32'(sb_q.size() <= 20), 32'd1);
    pc = 32'hFFFF_FFFF; final_flag = 1'b1;
    push_frame(32'hFFFF_FFFF, 32'h0000_00AF, 1'b1);
    drain("drain_frames_ab");

    // Reset while EN is high
    sb_on = 1'b0;
    for (int i = 0; i < 50 && !LCD_en; i++) @(negedge clk);
    chk("en_high_before_rst", 32'(LCD_en), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("midrst_en",   32'(LCD_en), 32'd0);
    chk("midrst_data", 32'(LCD_data), 32'h0);
    chk("midrst_blon", 32'(LCD_blon), 32'd0);
    repeat (3) @(negedge clk);

    register = 32'h1234_5ABC; final_flag = 1'b0;
    sb_q.delete();
    push_init();
    push_frame(32'hFFFF_FFFF, 32'h1234_5ABC, 1'b0);
    sb_on = 1'b1;
    rst = 1'b0;
    pwrup_check("pwrup2");
    drain("drain_after_reset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
